// File: rtl/ripple_count_capture_if.sv
// Bundle between the ripple-counter sampler and its clk-domain consumer.
// The master drives the raw counter and clear; the slave reports results.
interface ripple_count_capture_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] cnt_in;
    logic             clr;
    logic [WIDTH-1:0] cnt_sync;
    logic             cnt_valid;
    logic             step_pulse;
    logic             wrap_pulse;
    logic             skip_err;
    logic             err_sticky;
    logic [7:0]       wrap_count;

    modport master (
        output cnt_in, clr,
        input  cnt_sync, cnt_valid, step_pulse,
        input  wrap_pulse, skip_err, err_sticky,
        input  wrap_count
    );

    modport slave (
        input  cnt_in, clr,
        output cnt_sync, cnt_valid, step_pulse,
        output wrap_pulse, skip_err, err_sticky,
        output wrap_count
    );
endinterface

// File: rtl/ripple_count_capture.sv
// Samples an asynchronous ripple down-counter into the clk domain,
// filters settling glitches and classifies each accepted change.
module ripple_count_capture #(
    parameter int WIDTH         = 3,
    parameter int STABLE_CYCLES = 2
) (
    input logic                  clk,
    input logic                  rst,
    ripple_count_capture_if.slave bus
);
    typedef enum logic {INIT, TRACK} state_t;

    localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES);

    state_t           state, state_n;
    logic [WIDTH-1:0] s1, s2, cand;
    logic [3:0]       stab;
    logic [WIDTH-1:0] sync_q, sync_n;
    logic             valid_q, valid_n;
    logic             step_q, step_n;
    logic             wrap_q, wrap_n;
    logic             skip_q, skip_n;
    logic             sticky_q, sticky_n;
    logic [7:0]       wc_q, wc_n, wc_base;
    logic             accept, dec, at_zero;

    // A value is only taken once it has settled; in TRACK an
    // unchanged candidate is not re-accepted.
    assign accept  = (stab == STAB_MAX) &&
                     ((state == INIT) || (cand != sync_q));
    assign dec     = (cand == sync_q - WIDTH'(1));
    assign at_zero = (sync_q == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1       <= '1;
            s2       <= '1;
            cand     <= '1;
            stab     <= 4'd0;
            state    <= INIT;
            sync_q   <= '1;
            valid_q  <= 1'b0;
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
            skip_q   <= 1'b0;
            sticky_q <= 1'b0;
            wc_q     <= 8'd0;
        end else begin
            s1 <= bus.cnt_in;
            s2 <= s1;
            if (s2 == cand) begin
                if (stab != STAB_MAX)
                    stab <= stab + 4'd1;
            end else begin
                cand <= s2;
                stab <= 4'd1;
            end
            state    <= state_n;
            sync_q   <= sync_n;
            valid_q  <= valid_n;
            step_q   <= step_n;
            wrap_q   <= wrap_n;
            skip_q   <= skip_n;
            sticky_q <= sticky_n;
            wc_q     <= wc_n;
        end
    end

    always_comb begin
        state_n = state;
        sync_n  = sync_q;
        valid_n = valid_q;
        step_n  = 1'b0;
        wrap_n  = 1'b0;
        skip_n  = 1'b0;
        if (accept) begin
            sync_n = cand;
            unique case (state)
                INIT: begin
                    valid_n = 1'b1;
                    state_n = TRACK;
                end
                TRACK: begin
                    unique case (1'b1)
                        dec && at_zero: begin
                            step_n = 1'b1;
                            wrap_n = 1'b1;
                        end
                        dec && !at_zero: step_n = 1'b1;
                        !dec:            skip_n = 1'b1;
                    endcase
                end
            endcase
        end
        // A wrap or error in the clearing cycle survives the clear.
        wc_base  = bus.clr ? 8'd0 : wc_q;
        wc_n     = (wrap_n && wc_base != 8'hFF) ? wc_base + 8'd1 : wc_base;
        sticky_n = skip_n | (sticky_q & ~bus.clr);
    end

    assign bus.cnt_sync   = sync_q;
    assign bus.cnt_valid  = valid_q;
    assign bus.step_pulse = step_q;
    assign bus.wrap_pulse = wrap_q;
    assign bus.skip_err   = skip_q;
    assign bus.err_sticky = sticky_q;
    assign bus.wrap_count = wc_q;
endmodule

// File: tb/tb_ripple_count_capture.sv
// Directed bench for ripple_count_capture with an expected-result queue.
module tb_ripple_count_capture;
    logic clk = 1'b0;
    logic rst;

    ripple_count_capture_if #(.WIDTH(3)) bus ();

    ripple_count_capture #(.WIDTH(3), .STABLE_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [2:0] sync;
        logic       valid;
        logic       step;
        logic       wrap;
        logic       skip;
        logic       sticky;
        logic [7:0] wc;
    } exp_t;

    exp_t       sbq[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    logic [2:0] cur;
    logic [7:0] exp_wc;
    logic       exp_sticky;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_pop();
        exp_t e;
        if (sbq.size() == 0) begin
            chk("sb_underflow", 32'(sbq.size()), 32'd1);
            return;
        end
        e = sbq.pop_front();
        chk({e.tag, ".sync"},   32'(bus.cnt_sync),   32'(e.sync));
        chk({e.tag, ".valid"},  32'(bus.cnt_valid),  32'(e.valid));
        chk({e.tag, ".step"},   32'(bus.step_pulse), 32'(e.step));
        chk({e.tag, ".wrap"},   32'(bus.wrap_pulse), 32'(e.wrap));
        chk({e.tag, ".skip"},   32'(bus.skip_err),   32'(e.skip));
        chk({e.tag, ".sticky"}, 32'(bus.err_sticky), 32'(e.sticky));
        chk({e.tag, ".wc"},     32'(bus.wrap_count), 32'(e.wc));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".quiet"},
            32'({bus.step_pulse, bus.wrap_pulse, bus.skip_err}), 32'd0);
    endtask

    task automatic push(input string tag, input logic [2:0] v,
                        input bit st, input bit wr, input bit sk,
                        input bit clr_hit);
        exp_t       e;
        logic [7:0] base;
        base = clr_hit ? 8'd0 : exp_wc;
        if (wr && base != 8'hFF) base = base + 8'd1;
        exp_wc     = base;
        exp_sticky = sk | (exp_sticky & !clr_hit);
        e = '{tag, v, 1'b1, st, wr, sk, exp_sticky, exp_wc};
        sbq.push_back(e);
    endtask

    // Drive v right after edge 0; acceptance is due at edge 5.
    task automatic step_to(input logic [2:0] v, input bit st,
                           input bit wr, input bit sk,
                           input bit clr_hit, input string tag);
        push(tag, v, st, wr, sk, clr_hit);
        @(posedge clk); #1 bus.cnt_in = v;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); @(negedge clk);
            chk({tag, ".hold"}, 32'(bus.cnt_sync), 32'(cur));
            chk_quiet(tag);
            if (clr_hit && i == 4) bus.clr = 1'b1;
        end
        @(posedge clk); @(negedge clk);
        bus.clr = 1'b0;
        chk_pop();
        cur = v;
        @(posedge clk); @(negedge clk);
        chk_quiet({tag, ".after"});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".sync"},   32'(bus.cnt_sync),   32'h7);
        chk({tag, ".valid"},  32'(bus.cnt_valid),  32'd0);
        chk_quiet(tag);
        chk({tag, ".sticky"}, 32'(bus.err_sticky), 32'd0);
        chk({tag, ".wc"},     32'(bus.wrap_count), 32'd0);
    endtask

    task automatic drive_hold(input logic [2:0] v);
        @(posedge clk); #1 bus.cnt_in = v;
        repeat (5) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        bus.clr    = 1'b0;
        bus.cnt_in = 3'b111;
        exp_wc     = 8'd0;
        exp_sticky = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");

        // First acceptance after release: no pulses.
        push("init", 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_pop();
        cur = 3'b111;

        step_to(3'b110, 1, 0, 0, 0, "step110");

        // One-cycle glitch to 100 must be ignored.
        @(posedge clk); #1 bus.cnt_in = 3'b100;
        step_to(3'b101, 1, 0, 0, 0, "glitch");

        step_to(3'b110, 0, 0, 1, 0, "skip_up");
        @(posedge clk); #1 bus.clr = 1'b1;
        @(posedge clk); #1 bus.clr = 1'b0;
        @(negedge clk);
        exp_sticky = 1'b0;
        chk("clr1.sticky", 32'(bus.err_sticky), 32'd0);

        step_to(3'b011, 0, 0, 1, 0, "skip011");
        chk("skip011.sticky_hold", 32'(bus.err_sticky), 32'd1);
        @(posedge clk); #1 bus.clr = 1'b1;
        @(posedge clk); #1 bus.clr = 1'b0;
        @(negedge clk);
        exp_sticky = 1'b0;
        chk("clr2.sticky", 32'(bus.err_sticky), 32'd0);

        for (int v = 2; v >= 0; v--)
            step_to(3'(v), 1, 0, 0, 0, "down");
        step_to(3'b111, 1, 1, 0, 0, "wrap1");

        for (int v = 6; v >= 0; v--)
            step_to(3'(v), 1, 0, 0, 0, "down2");
        step_to(3'b111, 1, 1, 0, 1, "wrap_clr");
        step_to(3'b101, 0, 0, 1, 1, "skip_clr");

        @(posedge clk); #1 bus.clr = 1'b1;
        @(posedge clk); #1 bus.clr = 1'b0;
        @(negedge clk);
        exp_sticky = 1'b0;
        exp_wc     = 8'd0;
        chk("clr3.sticky", 32'(bus.err_sticky), 32'd0);
        chk("clr3.wc",     32'(bus.wrap_count), 32'd0);

        for (int v = 4; v >= 0; v--)
            step_to(3'(v), 1, 0, 0, 0, "down3");
        step_to(3'b111, 1, 1, 0, 0, "wrap_a");

        // 299 more wraps, 300 in total since the clear.
        for (int w = 0; w < 299; w++) begin
            for (int v = 6; v >= 0; v--) drive_hold(3'(v));
            drive_hold(3'b111);
        end
        exp_wc = 8'd255;
        chk("sat.wc", 32'(bus.wrap_count), 32'd255);

        for (int v = 6; v >= 0; v--)
            step_to(3'(v), 1, 0, 0, 0, "down4");
        step_to(3'b111, 1, 1, 0, 0, "wrap_sat");
        step_to(3'b110, 1, 0, 0, 0, "pre_rst");

        // Reset while a 111 candidate is still settling.
        @(posedge clk); #1 bus.cnt_in = 3'b111;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk_reset("mid_rst");
        exp_wc     = 8'd0;
        exp_sticky = 1'b0;
        push("post_rst", 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); @(negedge clk);
            chk_quiet("post_rst");
        end
        chk_pop();

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ripple_count_capture.md
RIPPLE_COUNT_CAPTURE -- requirements
Module: ripple_count_capture

Interface
REQ-001 Parameter WIDTH, default 3, width of the sampled ripple-counter value.
REQ-002 Parameter STABLE_CYCLES, default 2, number of consecutive equal synchronized samples required to accept a value; legal range 1..15.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 cnt_in  input  WIDTH  asynchronous ripple down-counter output, unrelated to clk.
REQ-006 clr  input  1  synchronous clear of wrap_count and err_sticky.
REQ-007 cnt_sync  output  WIDTH  last accepted counter value in the clk domain.
REQ-008 cnt_valid  output  1  high once a first value has been accepted after reset.
REQ-009 step_pulse  output  1  one-cycle pulse on an accepted decrement by exactly 1.
REQ-010 wrap_pulse  output  1  one-cycle pulse on an accepted 0 -> all-ones transition.
REQ-011 skip_err  output  1  one-cycle pulse on an accepted change that is not a decrement by 1.
REQ-012 err_sticky  output  1  set by skip_err; held until clr or reset.
REQ-013 wrap_count  output  8  saturating count of wrap events.

Function
REQ-014 Synchronizer: two flops, s1 <= cnt_in, s2 <= s1, every cycle.
REQ-015 Stability filter: if s2 == cand, stab <= min(stab+1, STABLE_CYCLES); else cand <= s2, stab <= 1.
REQ-016 Acceptance condition: stab == STABLE_CYCLES, and either state == INIT or cand != cnt_sync.
REQ-017 States: INIT (no value accepted yet) and TRACK.
REQ-018 INIT: on acceptance, cnt_sync <= cand, cnt_valid <= 1, go to TRACK; no step_pulse, wrap_pulse or skip_err.
REQ-019 TRACK: on acceptance, cnt_sync <= cand, and exactly one of the following applies.
REQ-020 TRACK decrement case: if cand == cnt_sync - 1 mod 2^WIDTH, step_pulse = 1.
REQ-021 TRACK wrap case: if in addition cnt_sync == 0, wrap_pulse = 1 and wrap_count increments.
REQ-022 TRACK error case: on any other change, skip_err = 1 and err_sticky <= 1.
REQ-023 Output timing: all pulses are registered, asserted in the same cycle cnt_sync shows the new value, and deasserted the following cycle unless re-triggered.
REQ-024 Latency: with cnt_in stable from before edge 1, cnt_sync updates at edge 3+STABLE_CYCLES (edge 5 at default).
REQ-025 Glitch rejection: any s2 value held for fewer than STABLE_CYCLES cycles is never accepted and produces no pulse.
REQ-026 wrap_count saturates at 255; further wraps still pulse wrap_pulse.
REQ-027 clr: wrap_count <= 0, err_sticky <= 0.
REQ-028 clr coinciding with a wrap gives wrap_count = 1; clr coinciding with skip_err gives err_sticky = 1.
REQ-029 cnt_sync holds its value between acceptances; TRACK never returns to INIT except via reset.

Reset
REQ-030 With rst low at a rising edge, the following load: s1, s2, cand and cnt_sync = all-ones; stab = 0; state = INIT; cnt_valid, step_pulse, wrap_pulse, skip_err and err_sticky = 0; wrap_count = 0.
REQ-031 Reset applied mid-operation discards any pending candidate; the first acceptance after release follows the INIT rules.
REQ-032 rst has priority over clr and over all other updates.

Verification
REQ-033 Reset then cnt_in = 111 constant -> cnt_valid = 1 and cnt_sync = 111 at edge 5 after release, with no pulses.
REQ-034 TRACK at 111, cnt_in -> 110 -> step_pulse for one cycle at edge 5, cnt_sync = 110, skip_err = 0.
REQ-035 TRACK at 000, cnt_in -> 111 -> wrap_pulse and step_pulse for one cycle, wrap_count 0 -> 1; after 300 wraps, wrap_count = 255.
REQ-036 TRACK at 110, cnt_in = 100 for one cycle then 101 stable -> no response to 100; a single step_pulse with cnt_sync = 101.
REQ-037 TRACK at 110, cnt_in -> 011 stable -> skip_err pulse and err_sticky = 1; then clr -> err_sticky = 0.
REQ-038 Reset asserted while a candidate is mid-filter -> all outputs at reset values; next accepted value produces no pulse and sets cnt_valid.
